// File: rtl/lut_interp_pkg.sv
// Shared widths and types for the activation-LUT interpolator.
// The integer and fractional fields of x must exactly fill DATA_W.
package lut_interp_pkg;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned ADDR_W = 4;
   localparam int unsigned FRAC_W = 4;

   typedef logic signed [DATA_W-1:0]        data_t;
   typedef logic        [ADDR_W-1:0]        addr_t;
   typedef logic        [FRAC_W-1:0]        frac_t;
   typedef logic signed [DATA_W:0]          diff_t;
   typedef logic signed [DATA_W+FRAC_W+1:0] prod_t;
   typedef logic signed [DATA_W+1:0]        sum_t;

endpackage

// File: rtl/lut_interp_mac.sv
// Combinational interpolation datapath: base + (next - base) * frac / 2^FRAC_W.
// Build option: define LUT_INTERP_ROUND_EN for round-half-up; otherwise the
// arithmetic shift truncates toward minus infinity.
module lut_interp_mac
   import lut_interp_pkg::*;
(
   input  logic [DATA_W-1:0] lut_base,
   input  logic [DATA_W-1:0] lut_next,
   input  logic [FRAC_W-1:0] frac,
   output logic [DATA_W+1:0] sum
);

`ifdef LUT_INTERP_ROUND_EN
   localparam int unsigned RND_VAL = 1 << (FRAC_W - 1);
`else
   localparam int unsigned RND_VAL = 0;
`endif
   localparam prod_t RND = prod_t'(RND_VAL);

   data_t                    base_s;
   data_t                    next_s;
   logic signed [FRAC_W:0]   frac_s;
   diff_t                    diff;
   prod_t                    prod;
   prod_t                    prod_rnd;
   prod_t                    shifted;
   sum_t                     sum_s;

   // Signed difference, weighted by the unsigned fraction, rescaled onto base.
   always_comb begin
      base_s   = lut_base;
      next_s   = lut_next;
      frac_s   = {1'b0, frac};
      diff     = diff_t'(next_s) - diff_t'(base_s);
      prod     = prod_t'(diff) * prod_t'(frac_s);
      prod_rnd = prod + RND;
      shifted  = prod_rnd >>> FRAC_W;
      // |shifted| never exceeds |diff|, so narrowing to sum_t is lossless
      sum_s    = sum_t'(base_s) + sum_t'(shifted);
   end

   assign sum = sum_s;

endmodule

// File: rtl/lut_interpolator.sv
// Two-stage LUT interpolator: S1 registers the LUT address and fraction,
// S2 registers the interpolated result. One global advance signal stalls
// both stages together under downstream back-pressure.
// Build option: LUT_INTERP_ROUND_EN selects rounding in lut_interp_mac.
module lut_interpolator
   import lut_interp_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_x,
   output logic [ADDR_W-1:0] lut_addr,
   input  logic [DATA_W-1:0] lut_base,
   input  logic [DATA_W-1:0] lut_next,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_y
);

   if (DATA_W != ADDR_W + FRAC_W) begin : g_width_check
      $error("lut_interpolator: DATA_W must equal ADDR_W + FRAC_W");
   end

   logic              adv;
   addr_t             addr_q;
   frac_t             frac_q;
   logic              v1_q;
   logic              out_valid_q;
   data_t             y_q;
   logic [DATA_W+1:0] sum;

   assign adv       = !out_valid_q | out_ready;
   assign in_ready  = adv;
   assign lut_addr  = addr_q;
   assign out_valid = out_valid_q;
   assign out_y     = y_q;

   // S1: capture the split input; addr/frac only reload on a real accept.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1_q   <= 1'b0;
         addr_q <= '0;
         frac_q <= '0;
      end else if (adv) begin
         v1_q <= in_valid;
         if (in_valid) begin
            addr_q <= in_x[DATA_W-1:FRAC_W];
            frac_q <= in_x[FRAC_W-1:0];
         end
      end
   end

   lut_interp_mac u_mac (
      .lut_base (lut_base),
      .lut_next (lut_next),
      .frac     (frac_q),
      .sum      (sum)
   );

   // S2: register the interpolated value alongside the forwarded valid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         y_q         <= '0;
      end else if (adv) begin
         out_valid_q <= v1_q;
         y_q         <= sum[DATA_W-1:0];
      end
   end

   // The result must lie between base and next, so the top bits are pure sign.
   sum_fits: assert property (@(posedge clk) disable iff (rst)
      v1_q |-> (sum[DATA_W+1:DATA_W-1] == {3{sum[DATA_W-1]}}));

endmodule

// File: tb/tb_lut_interpolator.sv
// Self-checking bench for lut_interpolator with an in-bench LUT that
// clamps at address 7 and wraps 15 -> 0, plus an arithmetic reference model.
module tb_lut_interpolator;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_x;
   logic [3:0] lut_addr;
   logic [7:0] lut_base;
   logic [7:0] lut_next;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_y;

   int nvec = 0;
   int nerr = 0;

   logic signed [7:0] lut [16];

   always #5 clk = ~clk;

   // LUT behaviour: combinational read, next entry clamps at 7 and wraps at 15
   always_comb begin
      lut_base = lut[lut_addr];
      lut_next = (lut_addr == 4'd7) ? lut[7] : lut[lut_addr + 4'd1];
   end

   lut_interpolator dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_x      (in_x),
      .lut_addr  (lut_addr),
      .lut_base  (lut_base),
      .lut_next  (lut_next),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_y     (out_y)
   );

   function automatic int floor_div16(int n);
      int q;
      q = n / 16;
      if ((n % 16 != 0) && (n < 0)) q = q - 1;
      return q;
   endfunction

   function automatic int model(logic [7:0] x);
      int a, f, b, nx, rnd;
      a  = int'(x[7:4]);
      f  = int'(x[3:0]);
      b  = int'(lut[a]);
      nx = (a == 7) ? int'(lut[7]) : int'(lut[(a + 1) % 16]);
`ifdef LUT_INTERP_ROUND_EN
      rnd = 8;
`else
      rnd = 0;
`endif
      return b + floor_div16((nx - b) * f + rnd);
   endfunction

   task automatic default_lut();
      for (int k = 0; k < 16; k++) lut[k] = (k < 8) ? 8'(16 * k) : 8'sd0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      @(negedge clk);
      nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
      nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
      nvec++; if (lut_addr !== 4'd0) begin nerr++; $display("FAIL reset_lut_addr: got %0d want 0", lut_addr); end
      nvec++; if (out_y !== 8'd0) begin nerr++; $display("FAIL reset_out_y: got %0d want 0", out_y); end
      rst = 1'b0;
      @(negedge clk);
      nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL post_reset_in_ready: got %0b want 1", in_ready); end
   endtask

   task automatic test_directed();
      logic [7:0] xs [4] = '{8'h25, 8'h7F, 8'hF8, 8'h40};
      int         ys [4] = '{37, 112, 0, 64};
      for (int i = 0; i < 4; i++) begin
         out_ready = 1'b1;
         in_valid  = 1'b1;
         in_x      = xs[i];
         @(negedge clk);
         in_valid = 1'b0;
         nvec++; if (lut_addr !== xs[i][7:4]) begin nerr++; $display("FAIL directed_addr x=%h: got %0d want %0d", xs[i], lut_addr, xs[i][7:4]); end
         nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL directed_early_valid x=%h: got %0b want 0", xs[i], out_valid); end
         @(negedge clk);
         nvec++; if (out_valid !== 1'b1) begin nerr++; $display("FAIL directed_valid x=%h: got %0b want 1", xs[i], out_valid); end
         nvec++; if (int'($signed(out_y)) != ys[i]) begin nerr++; $display("FAIL directed_y x=%h: got %0d want %0d", xs[i], $signed(out_y), ys[i]); end
      end
   endtask

   task automatic test_rounding();
      int want;
`ifdef LUT_INTERP_ROUND_EN
      want = 12;
`else
      want = 11;
`endif
      lut[3] = 8'sd10;
      lut[4] = 8'sd13;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_x      = 8'h3A;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      nvec++; if (out_valid !== 1'b1) begin nerr++; $display("FAIL rounding_valid: got %0b want 1", out_valid); end
      nvec++; if (int'($signed(out_y)) != want) begin nerr++; $display("FAIL rounding_y: got %0d want %0d", $signed(out_y), want); end
      default_lut();
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int         sent = 0;
      int         got  = 0;
      int         cyc  = 0;
      logic [7:0] held = 8'd0;
      logic       held_v = 1'b0;
      logic       want_ready;
      while (got < 16 && cyc < 80) begin
         out_ready = !(cyc inside {6, 7, 8});
         in_valid  = (sent < 16);
         in_x      = 8'(sent);
         #1;
         want_ready = !(out_valid && !out_ready);
         nvec++; if (in_ready !== want_ready) begin nerr++; $display("FAIL bp_in_ready cyc=%0d: got %0b want %0b", cyc, in_ready, want_ready); end
         if (out_valid && !out_ready) begin
            if (held_v) begin
               nvec++; if (out_y !== held) begin nerr++; $display("FAIL bp_hold cyc=%0d: got %0d want %0d", cyc, out_y, held); end
            end
            held   = out_y;
            held_v = 1'b1;
         end else begin
            held_v = 1'b0;
         end
         if (out_valid && out_ready) begin
            nvec++; if (int'(out_y) != got) begin nerr++; $display("FAIL bp_order idx=%0d: got %0d want %0d", got, out_y, got); end
            got++;
         end
         if (in_valid && in_ready) sent++;
         @(negedge clk);
         cyc++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      nvec++; if (got != 16) begin nerr++; $display("FAIL bp_count: got %0d results want 16", got); end
      #1;
      nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL bp_extra: got out_valid %0b want 0", out_valid); end
      @(negedge clk);
   endtask

   task automatic test_reset_midflight();
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_x      = 8'h25;
      @(negedge clk);
      in_x = 8'h40;
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      #1;
      nvec++; if (out_valid !== 1'b1) begin nerr++; $display("FAIL mid_full: got %0b want 1", out_valid); end
      #1 rst = 1'b1;
      #1;
      nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL mid_async_valid: got %0b want 0", out_valid); end
      nvec++; if (lut_addr !== 4'd0) begin nerr++; $display("FAIL mid_async_addr: got %0d want 0", lut_addr); end
      nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL mid_in_ready: got %0b want 1", in_ready); end
      #1 rst = 1'b0;
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL mid_stale: got %0b want 0", out_valid); end
      in_valid = 1'b1;
      in_x     = 8'h40;
      @(negedge clk);
      in_valid = 1'b0;
      nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL mid_latency_early: got %0b want 0", out_valid); end
      @(negedge clk);
      nvec++; if (out_valid !== 1'b1) begin nerr++; $display("FAIL mid_latency_valid: got %0b want 1", out_valid); end
      nvec++; if (int'($signed(out_y)) != 64) begin nerr++; $display("FAIL mid_latency_y: got %0d want 64", $signed(out_y)); end
      @(negedge clk);
   endtask

   task automatic test_throughput();
      int   exp_q [$];
      int   n_in = 0;
      int   n_out = 0;
      int   want;
      logic want_v;
      for (int k = 0; k < 16; k++) lut[k] = 8'($urandom_range(0, 255));
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 104; cyc++) begin
         in_valid = (n_in < 100);
         in_x     = 8'($urandom);
         #1;
         want_v = (cyc >= 2) && (cyc <= 101);
         nvec++; if (out_valid !== want_v) begin nerr++; $display("FAIL tp_valid cyc=%0d: got %0b want %0b", cyc, out_valid, want_v); end
         if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               nerr++; $display("FAIL tp_spurious cyc=%0d: got %0d want none", cyc, $signed(out_y));
            end else begin
               want = exp_q.pop_front();
               nvec++; if (int'($signed(out_y)) != want) begin nerr++; $display("FAIL tp_y idx=%0d: got %0d want %0d", n_out, $signed(out_y), want); end
               n_out++;
            end
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(model(in_x));
            n_in++;
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      nvec++; if (n_out != 100) begin nerr++; $display("FAIL tp_count: got %0d want 100", n_out); end
      default_lut();
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_x      = 8'd0;
      out_ready = 1'b1;
      default_lut();
      test_reset();
      test_directed();
      test_rounding();
      test_back_to_back();
      test_reset_midflight();
      test_throughput();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
